// File: rtl/mem_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_if
// Description : Bundles the fetch (i_*), data (d_*) and shared-memory (m_*)
//               valid/data_ok handshake signals of mem_bus_arbiter, plus the
//               owner status output.
//               master : the arbiter's view (drives m_* and the completions).
//               slave  : the environment's view (requesters and memory).
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   localparam int STRB_W = DATA_W / 8;

   // Fetch requester
   logic              i_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              i_data_ok;
   logic [DATA_W-1:0] i_rdata;

   // Data requester
   logic              d_valid;
   logic [ADDR_W-1:0] d_addr;
   logic [2:0]        d_size;
   logic [STRB_W-1:0] d_strobe;
   logic [DATA_W-1:0] d_wdata;
   logic              d_data_ok;
   logic [DATA_W-1:0] d_rdata;

   // Shared memory port
   logic              m_valid;
   logic [ADDR_W-1:0] m_addr;
   logic [2:0]        m_size;
   logic [STRB_W-1:0] m_strobe;
   logic [DATA_W-1:0] m_wdata;
   logic              m_data_ok;
   logic [DATA_W-1:0] m_rdata;

   // Arbitration status
   logic [1:0]        owner;

   modport master (
      input  i_valid, i_addr,
      output i_data_ok, i_rdata,
      input  d_valid, d_addr, d_size, d_strobe, d_wdata,
      output d_data_ok, d_rdata,
      output m_valid, m_addr, m_size, m_strobe, m_wdata,
      input  m_data_ok, m_rdata,
      output owner
   );

   modport slave (
      output i_valid, i_addr,
      input  i_data_ok, i_rdata,
      output d_valid, d_addr, d_size, d_strobe, d_wdata,
      input  d_data_ok, d_rdata,
      input  m_valid, m_addr, m_size, m_strobe, m_wdata,
      output m_data_ok, m_rdata,
      input  owner
   );
endinterface
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one memory port between instruction fetch and data
//               access. Data has fixed priority; after MAX_D_STREAK
//               consecutive data grants with a fetch waiting, the fetch is
//               granted once. MAX_D_STREAK=0 gives strict data priority.
//               The winner's request is latched at grant, so requester
//               inputs are ignored until the memory answers with m_data_ok.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int MAX_D_STREAK = 4
) (
   input  wire logic          clk,
   input  wire logic          reset,
   mem_bus_arbiter_if.master  bus
);

   localparam int STRB_W   = DATA_W / 8;
   // Counter must hold values 0..MAX_D_STREAK; keep at least one bit so the
   // strict-priority build still has a legal (constant zero) register.
   localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);
   localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
   localparam bit  FAIRNESS_ON = (MAX_D_STREAK != 0);

   localparam logic [2:0] MSIZE4     = 3'b010;
   localparam logic [1:0] OWNER_NONE = 2'd0;
   localparam logic [1:0] OWNER_I    = 2'd1;
   localparam logic [1:0] OWNER_D    = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } state_t;

   state_t              state_q,  state_d;
   logic [STREAK_W-1:0] streak_q, streak_d;

   // Latched request of the current owner; drives the memory port directly.
   logic [ADDR_W-1:0]   addr_q;
   logic [2:0]          size_q;
   logic [STRB_W-1:0]   strobe_q;
   logic [DATA_W-1:0]   wdata_q;

   logic                m_valid_q;
   logic [1:0]          owner_q;

   logic                streak_full;
   logic                grant_i;
   logic                grant_d;
   logic                complete;

   // Grant decisions are only taken in IDLE; fetch wins when data is absent
   // or data has used up its allowed streak while fetch was waiting.
   assign streak_full = FAIRNESS_ON && (streak_q == STREAK_MAX);
   assign grant_i     = (state_q == IDLE) && bus.i_valid &&
                        (!bus.d_valid || streak_full);
   assign grant_d     = (state_q == IDLE) && bus.d_valid && !grant_i;
   // m_data_ok only counts while a transaction is outstanding.
   assign complete    = (state_q != IDLE) && bus.m_data_ok;

   // Next-state and streak bookkeeping.
   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d = BUSY_I;
            end else if (grant_d) begin
               state_d = BUSY_D;
            end
         end
         BUSY_I, BUSY_D: begin
            if (complete) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (grant_i) begin
         streak_d = '0;
      end else if (grant_d) begin
         if (!bus.i_valid) begin
            // No fetch waiting: the streak only measures starvation.
            streak_d = '0;
         end else if (streak_q != STREAK_MAX) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   // Arbiter state, request latch and registered port outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         streak_q  <= '0;
         addr_q    <= '0;
         size_q    <= '0;
         strobe_q  <= '0;
         wdata_q   <= '0;
         m_valid_q <= 1'b0;
         owner_q   <= OWNER_NONE;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;

         if (grant_i) begin
            // Fetches are always 32-bit reads.
            addr_q   <= bus.i_addr;
            size_q   <= MSIZE4;
            strobe_q <= '0;
            wdata_q  <= '0;
         end else if (grant_d) begin
            addr_q   <= bus.d_addr;
            size_q   <= bus.d_size;
            strobe_q <= bus.d_strobe;
            wdata_q  <= bus.d_wdata;
         end

         m_valid_q <= (state_d != IDLE);
         case (state_d)
            BUSY_I:  owner_q <= OWNER_I;
            BUSY_D:  owner_q <= OWNER_D;
            default: owner_q <= OWNER_NONE;
         endcase
      end
   end

   // Memory port is driven only from the latch.
   assign bus.m_valid  = m_valid_q;
   assign bus.m_addr   = addr_q;
   assign bus.m_size   = size_q;
   assign bus.m_strobe = strobe_q;
   assign bus.m_wdata  = wdata_q;
   assign bus.owner    = owner_q;

   // Completion passes straight through to the owner; the other side sees 0.
   assign bus.i_data_ok = (state_q == BUSY_I) && bus.m_data_ok;
   assign bus.d_data_ok = (state_q == BUSY_D) && bus.m_data_ok;
   assign bus.i_rdata   = bus.i_data_ok ? bus.m_rdata : '0;
   assign bus.d_rdata   = bus.d_data_ok ? bus.m_rdata : '0;

endmodule
`default_nettype wire
